count_cmd_conditioner: RTL and testbench

//  Upstream stage of the 2..5 wrapping up/down counter. Turns two raw, bouncy,

---
 rtl/count_ctrl_pkg.sv | 27 ++
 rtl/count_cmd_conditioner_if.sv | 14 +
 rtl/sync2.sv | 26 ++
 rtl/count_cmd_conditioner.sv | 153 +++++++++++++++
 tb/tb_count_cmd_conditioner.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the 2..5 up/down counter and its command conditioner.
//   state_e        : conditioner FSM state encoding
//   DIR_UP/DIR_DN  : values carried on the counter's Up line
//   max3()         : helper used to size the saturating counters
package count_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT_REL = 3'd0,
        IDLE     = 3'd1,
        DEBOUNCE = 3'd2,
        PRESS    = 3'd3,
        HOLD     = 3'd4,
        REPEAT   = 3'd5
    } state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/count_cmd_conditioner_if.sv
// Button/command bundle between the push-button front end and the counter.
//   nBtnUp, nBtnDn : raw active-low buttons (driven by master)
//   En, Up, Held   : conditioned command outputs (driven by slave)
// master = button/counter side, slave = the conditioner itself.
interface count_cmd_conditioner_if;
    logic nBtnUp;
    logic nBtnDn;
    logic En;
    logic Up;
    logic Held;

    modport master (output nBtnUp, output nBtnDn, input En, input Up, input Held);
    modport slave  (input nBtnUp, input nBtnDn, output En, output Up, output Held);
endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous active-low button.
//   Clk    : system clock
//   nReset : asynchronous active-low reset; both flops go to 1 (released)
//   d_i    : raw asynchronous input
//   q_o    : synchronised output
module sync2 (
    input  logic Clk,
    input  logic nReset,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/count_cmd_conditioner.sv
// Turns two raw, bouncy, active-low buttons into the En/Up command pair of the
// 2..5 wrapping counter: synchronise, debounce, edge-detect, optional
// auto-repeat while held. All state advances on posedge Clk.
//   Clk    : system clock
//   nReset : asynchronous active-low reset
//   bus    : slave side of count_cmd_conditioner_if
//            (nBtnUp/nBtnDn in, En/Up/Held out)
module count_cmd_conditioner
    import count_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16
) (
    input  logic                    Clk,
    input  logic                    nReset,
    count_cmd_conditioner_if.slave  bus
);
    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)) + 1;
    localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DLY_LIM  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LIM = CNT_W'(REPEAT_RATE - 1);

    // index 1 = up button, index 0 = down button
    logic [1:0] raw_n;
    logic [1:0] sync_n;

    assign raw_n = {bus.nBtnUp, bus.nBtnDn};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        sync2 u_sync (
            .Clk    (Clk),
            .nReset (nReset),
            .d_i    (raw_n[gi]),
            .q_o    (sync_n[gi])
        );
    end

    logic up_p, dn_p, lat_p, other_p;
    assign up_p    = ~sync_n[1];
    assign dn_p    = ~sync_n[0];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, rpt_q, rpt_d;
    logic [CNT_W-1:0] cnt_inc, rpt_inc;
    logic             dir_q, dir_d;
    logic             up_q, up_d;
    logic             en_o, held_o;

    // "latched" = the button that started this press; "other" = its partner
    assign lat_p   = (dir_q == DIR_UP) ? up_p : dn_p;
    assign other_p = (dir_q == DIR_UP) ? dn_p : up_p;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign rpt_inc = (rpt_q == '1) ? rpt_q : rpt_q + 1'b1;

    // State register
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= WAIT_REL;
            cnt_q   <= '0;
            rpt_q   <= '0;
            dir_q   <= DIR_UP;
            up_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
            dir_q   <= dir_d;
            up_q    <= up_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        dir_d   = dir_q;
        unique case (state_q)
            WAIT_REL: begin
                if (up_p || dn_p) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LIM) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (up_p && dn_p) begin
                    state_d = WAIT_REL;
                end else if (up_p) begin
                    state_d = DEBOUNCE;
                    dir_d   = DIR_UP;
                end else if (dn_p) begin
                    state_d = DEBOUNCE;
                    dir_d   = DIR_DN;
                end
            end
            DEBOUNCE: begin
                if (!lat_p || other_p) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LIM) begin
                    state_d = PRESS;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESS: begin
                state_d = HOLD;
                cnt_d   = '0;
                rpt_d   = '0;
            end
            HOLD: begin
                if (!lat_p) begin
                    state_d = WAIT_REL;
                end else if (REPEAT_EN && (rpt_inc == DLY_LIM)) begin
                    // Entering REPEAT with phase 0 emits a pulse right away,
                    // which puts it exactly REPEAT_DELAY cycles after PRESS.
                    state_d = REPEAT;
                    rpt_d   = '0;
                end else begin
                    rpt_d = rpt_inc;
                end
            end
            REPEAT: begin
                if (!lat_p) begin
                    state_d = WAIT_REL;
                end else begin
                    rpt_d = (rpt_q == RATE_LIM) ? '0 : rpt_inc;
                end
            end
            default: state_d = WAIT_REL;
        endcase
        // Up only moves on the edge where En rises for a fresh press.
        up_d = (state_d == PRESS) ? dir_q : up_q;
    end

    // Output logic
    always_comb begin
        en_o   = (state_q == PRESS) || ((state_q == REPEAT) && (rpt_q == '0));
        held_o = (state_q == HOLD) || (state_q == REPEAT);
    end

    assign bus.En   = en_o;
    assign bus.Up   = up_q;
    assign bus.Held = held_o;
endmodule

// File: tb/tb_count_cmd_conditioner.sv
module tb_count_cmd_conditioner;
    logic clk;
    logic rst_n;
    int   cyc;
    int   compared;
    int   mismatched;

    typedef struct {
        int   cyc;
        logic up;
    } exp_t;

    exp_t q_rep[$];
    exp_t q_one[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    count_cmd_conditioner_if bus_rep ();
    count_cmd_conditioner_if bus_one ();

    count_cmd_conditioner u_dut (
        .Clk    (clk),
        .nReset (rst_n),
        .bus    (bus_rep)
    );

    count_cmd_conditioner #(.REPEAT_EN(1'b0)) u_dut_norep (
        .Clk    (clk),
        .nReset (rst_n),
        .bus    (bus_one)
    );

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Scoreboard monitor, repeating instance
    always @(negedge clk) begin
        exp_t e;
        if (bus_rep.En === 1'b1) begin
            compared++;
            if (q_rep.size() == 0) begin
                mismatched++;
                $display("FAIL en_unexpected_rep: pulse at cycle %0d, none required", cyc);
            end else begin
                e = q_rep.pop_front();
                if (cyc != e.cyc || bus_rep.Up !== e.up) begin
                    mismatched++;
                    $display("FAIL en_pulse_rep: got cycle %0d Up %0b, required cycle %0d Up %0b",
                             cyc, bus_rep.Up, e.cyc, e.up);
                end
            end
        end else if (q_rep.size() > 0 && cyc > q_rep[0].cyc) begin
            compared++;
            mismatched++;
            $display("FAIL en_missing_rep: no pulse by cycle %0d, required at %0d", cyc, q_rep[0].cyc);
            e = q_rep.pop_front();
        end
    end

    // Scoreboard monitor, non-repeating instance
    always @(negedge clk) begin
        exp_t e;
        if (bus_one.En === 1'b1) begin
            compared++;
            if (q_one.size() == 0) begin
                mismatched++;
                $display("FAIL en_unexpected_one: pulse at cycle %0d, none required", cyc);
            end else begin
                e = q_one.pop_front();
                if (cyc != e.cyc || bus_one.Up !== e.up) begin
                    mismatched++;
                    $display("FAIL en_pulse_one: got cycle %0d Up %0b, required cycle %0d Up %0b",
                             cyc, bus_one.Up, e.cyc, e.up);
                end
            end
        end else if (q_one.size() > 0 && cyc > q_one[0].cyc) begin
            compared++;
            mismatched++;
            $display("FAIL en_missing_one: no pulse by cycle %0d, required at %0d", cyc, q_one[0].cyc);
            e = q_one.pop_front();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        compared   = 0;
        mismatched = 0;
        bus_rep.nBtnUp = 1'b1;
        bus_rep.nBtnDn = 1'b1;
        bus_one.nBtnUp = 1'b1;
        bus_one.nBtnDn = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_en_rep",   int'(bus_rep.En),   0);
        check("reset_up_rep",   int'(bus_rep.Up),   1);
        check("reset_held_rep", int'(bus_rep.Held), 0);
        check("reset_en_one",   int'(bus_one.En),   0);
        check("reset_up_one",   int'(bus_one.Up),   1);
        check("reset_held_one", int'(bus_one.Held), 0);
        $display("reset released at cycle %0d", cyc);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);

        // 1: single press, no repeat, held 100 cycles -> one pulse at +19
        p = cyc + 1;
        bus_one.nBtnUp = 1'b0;
        q_one.push_back('{p + 19, 1'b1});
        $display("t1 up press on non-repeating instance at edge %0d", p);
        wait_until(p + 50);
        check("t1_held", int'(bus_one.Held), 1);
        check("t1_up",   int'(bus_one.Up),   1);
        wait_until(p + 99);
        bus_one.nBtnUp = 1'b1;
        repeat (30) @(negedge clk);
        check("t1_held_after_release", int'(bus_one.Held), 0);

        // 2: down-button glitches shorter than the debounce window
        for (int i = 0; i < 3; i++) begin
            bus_rep.nBtnDn = 1'b0;
            repeat (5) @(negedge clk);
            bus_rep.nBtnDn = 1'b1;
            repeat (5) @(negedge clk);
            $display("t2 glitch %0d done at cycle %0d", i, cyc);
        end
        repeat (30) @(negedge clk);
        check("t2_up",   int'(bus_rep.Up),   1);
        check("t2_held", int'(bus_rep.Held), 0);

        // 3: down held 200 cycles with auto-repeat
        p = cyc + 1;
        bus_rep.nBtnDn = 1'b0;
        q_rep.push_back('{p + 19, 1'b0});
        for (int k = 0; k < 8; k++) q_rep.push_back('{p + 83 + 16 * k, 1'b0});
        $display("t3 down press with repeat at edge %0d", p);
        wait_until(p + 19);
        check("t3_held_at_19", int'(bus_rep.Held), 0);
        wait_until(p + 20);
        check("t3_held_at_20", int'(bus_rep.Held), 1);
        wait_until(p + 199);
        bus_rep.nBtnDn = 1'b1;
        repeat (10) @(negedge clk);
        check("t3_held_after_release", int'(bus_rep.Held), 0);
        check("t3_up", int'(bus_rep.Up), 0);
        repeat (25) @(negedge clk);

        // 4: both buttons on the same edge for 50 cycles
        bus_rep.nBtnUp = 1'b0;
        bus_rep.nBtnDn = 1'b0;
        $display("t4 both pressed at cycle %0d", cyc);
        repeat (25) @(negedge clk);
        check("t4_held", int'(bus_rep.Held), 0);
        repeat (25) @(negedge clk);
        bus_rep.nBtnUp = 1'b1;
        bus_rep.nBtnDn = 1'b1;
        repeat (30) @(negedge clk);
        check("t4_up", int'(bus_rep.Up), 0);

        // 6: up held into HOLD, then down added; released together
        p = cyc + 1;
        bus_rep.nBtnUp = 1'b0;
        q_rep.push_back('{p + 19, 1'b1});
        $display("t6 up press at edge %0d, down added later", p);
        wait_until(p + 30);
        bus_rep.nBtnDn = 1'b0;
        wait_until(p + 60);
        check("t6_up",   int'(bus_rep.Up),   1);
        check("t6_held", int'(bus_rep.Held), 1);
        bus_rep.nBtnUp = 1'b1;
        bus_rep.nBtnDn = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_held_after_release", int'(bus_rep.Held), 0);
        repeat (25) @(negedge clk);

        // 5: reset pulsed while up is held
        p = cyc + 1;
        bus_rep.nBtnUp = 1'b0;
        q_rep.push_back('{p + 19, 1'b1});
        $display("t5 up press at edge %0d, reset at +40", p);
        wait_until(p + 40);
        rst_n = 1'b0;
        #1;
        check("t5_held_in_reset", int'(bus_rep.Held), 0);
        check("t5_en_in_reset",   int'(bus_rep.En),   0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_until(p + 100);
        check("t5_held_after_reset", int'(bus_rep.Held), 0);
        check("t5_up_after_reset",   int'(bus_rep.Up),   1);
        bus_rep.nBtnUp = 1'b1;
        repeat (25) @(negedge clk);
        p = cyc + 1;
        bus_rep.nBtnUp = 1'b0;
        q_rep.push_back('{p + 19, 1'b1});
        $display("t5 re-press at edge %0d", p);
        wait_until(p + 30);
        check("t5_held_repress", int'(bus_rep.Held), 1);
        bus_rep.nBtnUp = 1'b1;
        repeat (30) @(negedge clk);

        check("rep_queue_left", q_rep.size(), 0);
        check("one_queue_left", q_one.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
